// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes (common with the
// execute-stage ALU), divider state encoding and op decode helpers.
package mdu_pkg;

  localparam int CTRL_W = 5;

  localparam logic [CTRL_W-1:0] OP_DIV   = 5'b10011;
  localparam logic [CTRL_W-1:0] OP_DIVU  = 5'b10100;
  localparam logic [CTRL_W-1:0] OP_REM   = 5'b10101;
  localparam logic [CTRL_W-1:0] OP_REMU  = 5'b10110;
  localparam logic [CTRL_W-1:0] OP_DIVW  = 5'b11000;
  localparam logic [CTRL_W-1:0] OP_DIVUW = 5'b11001;
  localparam logic [CTRL_W-1:0] OP_REMW  = 5'b11010;
  localparam logic [CTRL_W-1:0] OP_REMUW = 5'b11011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } divState_e;

  // True for the 32-bit W-variant ops.
  function automatic logic isWordOp(input logic [CTRL_W-1:0] op);
    return (op == OP_DIVW) || (op == OP_DIVUW) || (op == OP_REMW) || (op == OP_REMUW);
  endfunction

  // True for ops that interpret operands as two's complement.
  function automatic logic isSignedOp(input logic [CTRL_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVW) || (op == OP_REMW);
  endfunction

  // True for ops that return the remainder rather than the quotient.
  function automatic logic isRemOp(input logic [CTRL_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
  endfunction

  // True for any op code this unit executes.
  function automatic logic isDivUnitOp(input logic [CTRL_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU) ||
           isWordOp(op);
  endfunction

endpackage

// File: rtl/mdu_divider_step.sv
// One restoring division step: shift {rem,quot} left by one, trial-subtract
// the divisor from the widened remainder and keep the difference when it is
// non-negative, recording that outcome as the new quotient bit.
module div_iter_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] remIn_i,
  input  logic [W-1:0] quotIn_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] remOut_o,
  output logic [W-1:0] quotOut_o
);

  logic [W:0]   shiftedRem;
  logic         trialOk;
  logic [W-1:0] trialDiff;

  // Restoring step; the difference fits in W bits whenever the trial succeeds
  // because the running remainder is always below the divisor.
  always_comb begin
    shiftedRem = {remIn_i, quotIn_i[W-1]};
    trialOk    = (shiftedRem >= {1'b0, divisor_i});
    trialDiff  = shiftedRem[W-1:0] - divisor_i;
    remOut_o   = trialOk ? trialDiff : shiftedRem[W-1:0];
    quotOut_o  = {quotIn_i[W-2:0], trialOk};
  end

endmodule

// File: rtl/mdu_divider.sv
// Iterative radix-2 divider for the RV64M divide/remainder ops. Operands are
// reduced to magnitudes at accept, divided one bit per cycle and sign-fixed on
// the final step; degenerate cases resolve immediately without iterating.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int WORD_WIDTH    = 32,
  parameter int CONTROL_WIDTH = CTRL_W
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_flush,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [CONTROL_WIDTH-1:0] i_op,
  input  logic [DATA_WIDTH-1:0]    i_src_1,
  input  logic [DATA_WIDTH-1:0]    i_src_2,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output logic [DATA_WIDTH-1:0]    o_result
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int EXT_W = DATA_WIDTH - WORD_WIDTH;

  divState_e             state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  quotNeg_q, quotNeg_d;
  logic                  remNeg_q, remNeg_d;
  logic                  isRem_q, isRem_d;
  logic                  isWord_q, isWord_d;

  logic                  opWord, opSigned, opRem, opValid;
  logic [DATA_WIDTH-1:0] srcA, srcB, magA, magB, mostNeg, dividendLoad;
  logic                  negA, negB, overflow;
  logic [DATA_WIDTH-1:0] stepRem, stepQuot, finalQuot, finalRem;

  // Narrow results of W ops are sign-extended from bit 31, unsigned ones too.
  function automatic logic [DATA_WIDTH-1:0] fitWord(input logic [DATA_WIDTH-1:0] value,
                                                    input logic word);
    if (word) return {{EXT_W{value[WORD_WIDTH-1]}}, value[WORD_WIDTH-1:0]};
    return value;
  endfunction

  div_iter_step #(.W(DATA_WIDTH)) u_step (
    .remIn_i   (rem_q),
    .quotIn_i  (quot_q),
    .divisor_i (divisor_q),
    .remOut_o  (stepRem),
    .quotOut_o (stepQuot)
  );

  // Decode the incoming request: W extension, magnitudes, operand signs and
  // the most-negative / -1 overflow case.
  always_comb begin
    opWord   = isWordOp(i_op);
    opSigned = isSignedOp(i_op);
    opRem    = isRemOp(i_op);
    opValid  = isDivUnitOp(i_op);
    if (opWord) begin
      srcA    = {{EXT_W{opSigned & i_src_1[WORD_WIDTH-1]}}, i_src_1[WORD_WIDTH-1:0]};
      srcB    = {{EXT_W{opSigned & i_src_2[WORD_WIDTH-1]}}, i_src_2[WORD_WIDTH-1:0]};
      mostNeg = {{(EXT_W + 1){1'b1}}, {(WORD_WIDTH - 1){1'b0}}};
    end else begin
      srcA    = i_src_1;
      srcB    = i_src_2;
      mostNeg = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
    negA         = opSigned & srcA[DATA_WIDTH-1];
    negB         = opSigned & srcB[DATA_WIDTH-1];
    magA         = negA ? -srcA : srcA;
    magB         = negB ? -srcB : srcB;
    dividendLoad = opWord ? (magA << EXT_W) : magA;
    overflow     = opSigned && (srcA == mostNeg) && (srcB == '1);
    finalQuot    = quotNeg_q ? -stepQuot : stepQuot;
    finalRem     = remNeg_q ? -stepRem : stepRem;
  end

  // Next-state logic: accept in IDLE, iterate in DIVIDE, hold result in DONE.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    quotNeg_d = quotNeg_q;
    remNeg_d  = remNeg_q;
    isRem_d   = isRem_q;
    isWord_d  = isWord_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid && !i_flush) begin
          isRem_d   = opRem;
          isWord_d  = opWord;
          quotNeg_d = negA ^ negB;
          remNeg_d  = negA;
          state_d   = DONE;
          if (!opValid) begin
            result_d = '0;
          end else if (srcB == '0) begin
            result_d = fitWord(opRem ? srcA : '1, opWord);
          end else if (overflow) begin
            result_d = fitWord(opRem ? '0 : srcA, opWord);
          end else begin
            rem_d     = '0;
            quot_d    = dividendLoad;
            divisor_d = magB;
            count_d   = opWord ? CNT_W'(WORD_WIDTH) : CNT_W'(DATA_WIDTH);
            state_d   = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        rem_d   = stepRem;
        quot_d  = stepQuot;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          result_d = fitWord(isRem_q ? finalRem : finalQuot, isWord_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      quotNeg_q <= 1'b0;
      remNeg_q  <= 1'b0;
      isRem_q   <= 1'b0;
      isWord_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      quotNeg_q <= quotNeg_d;
      remNeg_q  <= remNeg_d;
      isRem_q   <= isRem_d;
      isWord_q  <= isWord_d;
    end
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_resp_valid = (state_q == DONE);
  assign o_result     = result_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Scoreboard bench for mdu_divider: directed and random requests push their
// expected result and latency; an independent monitor pops and compares.
module tb_mdu_divider;

  localparam logic [4:0] OP_DIV   = 5'b10011;
  localparam logic [4:0] OP_DIVU  = 5'b10100;
  localparam logic [4:0] OP_REM   = 5'b10101;
  localparam logic [4:0] OP_REMU  = 5'b10110;
  localparam logic [4:0] OP_DIVW  = 5'b11000;
  localparam logic [4:0] OP_DIVUW = 5'b11001;
  localparam logic [4:0] OP_REMW  = 5'b11010;
  localparam logic [4:0] OP_REMUW = 5'b11011;
  localparam logic [63:0] MIN64   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] res;
    int          lat;
    time         acc;
  } expect_t;

  logic        clock;
  logic        arstN;
  logic        flush;
  logic        reqValid;
  logic        reqReady;
  logic [4:0]  op;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        respValid;
  logic        respReady;
  logic [63:0] result;

  int      checks;
  int      failures;
  expect_t sb[$];
  bit      holdReady;

  mdu_divider dut (
    .i_clk        (clock),
    .i_arst_n     (arstN),
    .i_flush      (flush),
    .i_req_valid  (reqValid),
    .o_req_ready  (reqReady),
    .i_op         (op),
    .i_src_1      (src1),
    .i_src_2      (src2),
    .o_resp_valid (respValid),
    .i_resp_ready (respReady),
    .o_result     (result)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
    end
  endtask

  // Reference result computed with plain signed/unsigned arithmetic.
  function automatic logic [63:0] refResult(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b);
    longint          sa, sbv;
    longint unsigned ua, ub;
    int              sa32, sb32, r32;
    int unsigned     ua32, ub32;
    sa = a; sbv = b; ua = a; ub = b;
    sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    case (o)
      OP_DIVU: return (ub == 0) ? ONES : ua / ub;
      OP_REMU: return (ub == 0) ? a : ua % ub;
      OP_DIV: begin
        if (sbv == 0) return ONES;
        if (a == MIN64 && sbv == -1) return a;
        return sa / sbv;
      end
      OP_REM: begin
        if (sbv == 0) return a;
        if (a == MIN64 && sbv == -1) return 64'd0;
        return sa % sbv;
      end
      OP_DIVW: begin
        if (sb32 == 0) r32 = -1;
        else if (ua32 == 32'h8000_0000 && sb32 == -1) r32 = sa32;
        else r32 = sa32 / sb32;
        return longint'(r32);
      end
      OP_DIVUW: begin
        r32 = (ub32 == 0) ? -1 : int'(ua32 / ub32);
        return longint'(r32);
      end
      OP_REMW: begin
        if (sb32 == 0) r32 = sa32;
        else if (ua32 == 32'h8000_0000 && sb32 == -1) r32 = 0;
        else r32 = sa32 % sb32;
        return longint'(r32);
      end
      OP_REMUW: begin
        r32 = (ub32 == 0) ? int'(ua32) : int'(ua32 % ub32);
        return longint'(r32);
      end
      default: return 64'd0;
    endcase
  endfunction

  // Expected cycles from accept to first valid response.
  function automatic int refLatency(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b);
    bit word, sgn;
    word = (o == OP_DIVW) || (o == OP_DIVUW) || (o == OP_REMW) || (o == OP_REMUW);
    sgn  = (o == OP_DIV) || (o == OP_REM) || (o == OP_DIVW) || (o == OP_REMW);
    if (!(word || o == OP_DIV || o == OP_DIVU || o == OP_REM || o == OP_REMU)) return 1;
    if (word) begin
      if (b[31:0] == 32'd0) return 1;
      if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 64'd0) return 1;
    if (sgn && a == MIN64 && b == ONES) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return ONES;
      2:       return MIN64;
      3:       return 64'($urandom_range(0, 100));
      4:       return {$urandom(), $urandom()};
      5:       return {32'hFFFF_FFFF, $urandom()};
      default: return {32'd0, $urandom()};
    endcase
  endfunction

  function automatic logic [4:0] randOp();
    case ($urandom_range(0, 8))
      0:       return OP_DIV;
      1:       return OP_DIVU;
      2:       return OP_REM;
      3:       return OP_REMU;
      4:       return OP_DIVW;
      5:       return OP_DIVUW;
      6:       return OP_REMW;
      7:       return OP_REMUW;
      default: return 5'b00111;
    endcase
  endfunction

  // Wait (bounded) for the unit to be ready, issue one request and log its expectation.
  task automatic applyStimulus(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] expRes, input int expLat);
    int guard;
    expect_t e;
    guard = 0;
    @(negedge clock);
    while (!reqReady && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (!reqReady) begin
      checks++;
      failures++;
      $display("[TB] FAIL req_ready_timeout: ready stayed 0, expected 1");
      return;
    end
    op       = o;
    src1     = a;
    src2     = b;
    reqValid = 1'b1;
    @(posedge clock);
    e.res = expRes;
    e.lat = expLat;
    e.acc = $time;
    sb.push_back(e);
    #1 reqValid = 1'b0;
  endtask

  // Response-ready driver: random backpressure unless held low.
  initial begin
    respReady = 1'b0;
    forever begin
      @(posedge clock);
      #1 respReady = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare each response against the scoreboard and check it stays stable.
  initial begin
    bit      inResp;
    bit      haveCur;
    expect_t cur;
    int      lat;
    inResp  = 0;
    haveCur = 0;
    forever begin
      @(negedge clock);
      if (respValid) begin
        if (!inResp) begin
          inResp = 1;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            haveCur = 0;
            $display("[TB] FAIL unexpected_resp: got result 0x%016h, expected no response", result);
          end else begin
            cur     = sb.pop_front();
            haveCur = 1;
            lat     = int'(($time - cur.acc - 5) / 10) + 1;
            checkOutput("latency", 64'(lat), 64'(cur.lat));
            checkOutput("result", result, cur.res);
          end
        end else if (haveCur) begin
          checkOutput("result_held", result, cur.res);
        end
        if (respReady) begin
          inResp  = 0;
          haveCur = 0;
        end
      end else begin
        inResp  = 0;
        haveCur = 0;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed cases, backpressure, flush, reset abort, random traffic.
  initial begin
    int guard;
    logic [4:0]  rop;
    logic [63:0] ra, rb;
    checks    = 0;
    failures  = 0;
    holdReady = 0;
    arstN     = 1'b0;
    flush     = 1'b0;
    reqValid  = 1'b0;
    op        = 5'd0;
    src1      = 64'd0;
    src2      = 64'd0;
    repeat (2) @(negedge clock);
    checkOutput("reset_req_ready", 64'(reqReady), 64'd1);
    checkOutput("reset_resp_valid", 64'(respValid), 64'd0);
    checkOutput("reset_result", result, 64'd0);
    arstN = 1'b1;

    applyStimulus(OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
    applyStimulus(OP_REMU, 64'd100, 64'd7, 64'd2, 65);
    applyStimulus(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    applyStimulus(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65);
    applyStimulus(OP_DIV, 64'd5, 64'd0, ONES, 1);
    applyStimulus(OP_REMUW, 64'h0000_0000_FFFF_FFFF, 64'd0, ONES, 1);
    applyStimulus(OP_DIV, MIN64, ONES, MIN64, 1);
    applyStimulus(OP_REM, MIN64, ONES, 64'd0, 1);
    applyStimulus(OP_DIVW, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 33);
    applyStimulus(OP_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
    applyStimulus(5'b00001, 64'd40, 64'd4, 64'd0, 1);

    // Backpressure: hold the response for 10 cycles; unit must not accept.
    holdReady = 1;
    applyStimulus(OP_DIVU, 64'd1000, 64'd10, 64'd100, 65);
    guard = 0;
    while (!respValid && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("bp_resp_valid", 64'(respValid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("bp_req_ready", 64'(reqReady), 64'd0);
    end
    holdReady = 0;

    // Flush during iteration 20: result dropped, unit idle next cycle.
    applyStimulus(OP_DIVU, 64'hFFFF_0000_1234_5678, 64'd3, 64'd0, 65);
    repeat (19) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    void'(sb.pop_back());
    checkOutput("flush_req_ready", 64'(reqReady), 64'd1);
    checkOutput("flush_resp_valid", 64'(respValid), 64'd0);
    repeat (70) @(posedge clock);
    applyStimulus(OP_DIVU, 64'd9, 64'd3, 64'd3, 65);

    // Flush in the same cycle as a request blocks acceptance.
    guard = 0;
    @(negedge clock);
    while (!reqReady && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    op       = OP_DIVU;
    src1     = 64'd50;
    src2     = 64'd5;
    reqValid = 1'b1;
    flush    = 1'b1;
    @(posedge clock);
    #1;
    reqValid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush_req_blocked", 64'(reqReady), 64'd1);

    // Flush in DONE while the consumer stalls drops the result.
    holdReady = 1;
    applyStimulus(OP_DIV, 64'd5, 64'd0, ONES, 1);
    @(negedge clock);
    @(posedge clock);
    #2 flush = 1'b1;
    @(posedge clock);
    #2 flush = 1'b0;
    checkOutput("flush_done_valid", 64'(respValid), 64'd0);
    holdReady = 0;

    // Asynchronous reset in the middle of a divide.
    applyStimulus(OP_DIVU, 64'd123456789, 64'd1000, 64'd123456, 65);
    repeat (10) @(posedge clock);
    #3 arstN = 1'b0;
    #1;
    checkOutput("arst_req_ready", 64'(reqReady), 64'd1);
    checkOutput("arst_resp_valid", 64'(respValid), 64'd0);
    checkOutput("arst_result", result, 64'd0);
    sb.delete();
    @(negedge clock);
    arstN = 1'b1;

    // Back-to-back directed then random traffic against the reference model.
    applyStimulus(OP_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 33);
    applyStimulus(OP_DIVU, 64'd9, 64'd3, 64'd3, 65);
    for (int i = 0; i < 30; i++) begin
      rop = randOp();
      ra  = randOperand();
      rb  = randOperand();
      applyStimulus(rop, ra, rb, refResult(rop, ra, rb), refLatency(rop, ra, rb));
    end

    guard = 0;
    while ((sb.size() != 0 || respValid) && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
